// File: rtl/alu_req_arbiter.sv
// ============================================================================
//  Module      : alu_req_arbiter
//  Description : Round-robin arbiter sharing one ALU between two requesters,
//                with valid/ready handshakes on command and response sides.
//                Optional macro ALU_ARB_OPCNT_EN adds per-requester op counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_req_arbiter #(
    parameter int IN_WIDTH  = 16,
    parameter int RES_WIDTH = 32,
    parameter int ALU_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [IN_WIDTH-1:0]  req0_a,
    input  logic [IN_WIDTH-1:0]  req0_b,
    input  logic [3:0]           req0_fun,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [IN_WIDTH-1:0]  req1_a,
    input  logic [IN_WIDTH-1:0]  req1_b,
    input  logic [3:0]           req1_fun,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [RES_WIDTH-1:0] rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_err,
    output logic                 busy,
`ifdef ALU_ARB_OPCNT_EN
    output logic [15:0]          op_cnt0,
    output logic [15:0]          op_cnt1,
`endif
    output logic [IN_WIDTH-1:0]  alu_a,
    output logic [IN_WIDTH-1:0]  alu_b,
    output logic [3:0]           alu_fun,
    input  logic [RES_WIDTH-1:0] alu_arith_out,
    input  logic                 alu_carry,
    input  logic [15:0]          alu_logic_out,
    input  logic [3:0]           alu_cmp_out,
    input  logic [16:0]          alu_shift_out,
    input  logic                 alu_arith_flag,
    input  logic                 alu_logic_flag,
    input  logic                 alu_cmp_flag,
    input  logic                 alu_shift_flag
);

    localparam int c_CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ALU_LAT);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 r_last;          // 1: requester 1 was served last
    logic                 r_owner;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [IN_WIDTH-1:0]  r_alu_a;
    logic [IN_WIDTH-1:0]  r_alu_b;
    logic [3:0]           r_alu_fun;
    logic [RES_WIDTH-1:0] r_rsp_data;
    logic                 r_rsp_carry;
    logic                 r_rsp_err;

    logic                 w_req0_ready;
    logic                 w_req1_ready;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_handshake;
    logic [RES_WIDTH-1:0] w_cap_data;
    logic                 w_cap_carry;
    logic                 w_cap_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_capture    = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            c_IDLE: begin
                // Ready is held low while reset is asserted so no output leaks a 1.
                if (!rst) begin
                    w_req0_ready = req0_valid && (!req1_valid || r_last);
                    w_req1_ready = req1_valid && (!req0_valid || !r_last);
                end
                if (w_req0_ready || w_req1_ready) begin
                    w_next_state = c_WAIT;
                end
            end
            c_WAIT: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_next_state = c_RESP;
                end
            end
            c_RESP: begin
                if ((!r_owner && rsp0_ready) || (r_owner && rsp1_ready)) begin
                    w_handshake  = 1'b1;
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    assign w_accept = w_req0_ready || w_req1_ready;

    always_comb begin
        w_cap_data  = '0;
        w_cap_carry = 1'b0;
        w_cap_err   = 1'b0;
        case (r_alu_fun[3:2])
            2'b00: begin
                w_cap_data  = alu_arith_out;
                w_cap_carry = alu_carry;
                w_cap_err   = !alu_arith_flag;
            end
            2'b01: begin
                w_cap_data = {{(RES_WIDTH-16){1'b0}}, alu_logic_out};
                w_cap_err  = !alu_logic_flag;
            end
            2'b10: begin
                w_cap_data = {{(RES_WIDTH-4){1'b0}}, alu_cmp_out};
                w_cap_err  = !alu_cmp_flag;
            end
            default: begin
                w_cap_data = {{(RES_WIDTH-17){1'b0}}, alu_shift_out};
                w_cap_err  = !alu_shift_flag;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_fun   <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= w_req1_ready ? req1_a   : req0_a;
                r_alu_b   <= w_req1_ready ? req1_b   : req0_b;
                r_alu_fun <= w_req1_ready ? req1_fun : req0_fun;
                r_owner   <= w_req1_ready;
                r_last    <= w_req1_ready;
                r_cnt     <= c_CNT_LOAD;
            end else if ((r_state == c_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
            if (w_capture) begin
                r_rsp_data  <= w_cap_data;
                r_rsp_carry <= w_cap_carry;
                r_rsp_err   <= w_cap_err;
            end
        end
    end

`ifdef ALU_ARB_OPCNT_EN
    logic [15:0] r_op_cnt0;
    logic [15:0] r_op_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_cnt0 <= '0;
            r_op_cnt1 <= '0;
        end else if (w_handshake) begin
            if (r_owner) begin
                r_op_cnt1 <= r_op_cnt1 + 16'd1;
            end else begin
                r_op_cnt0 <= r_op_cnt0 + 16'd1;
            end
        end
    end

    assign op_cnt0 = r_op_cnt0;
    assign op_cnt1 = r_op_cnt1;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_handshake;
`endif

    assign req0_ready = w_req0_ready;
    assign req1_ready = w_req1_ready;
    assign rsp0_valid = (r_state == c_RESP) && !r_owner;
    assign rsp1_valid = (r_state == c_RESP) && r_owner;
    assign rsp_data   = r_rsp_data;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != c_IDLE);
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_fun    = r_alu_fun;

endmodule

`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
// ============================================================================
//  Module      : tb_alu_req_arbiter
//  Description : Self-checking bench for alu_req_arbiter with a registered ALU
//                stand-in and an opcode-table reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_req_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_fun, req1_fun;
    logic [31:0] rsp_data;
    logic        rsp_carry, rsp_err, busy;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic [31:0] alu_arith_out = '0;
    logic        alu_carry = 1'b0;
    logic [15:0] alu_logic_out = '0;
    logic [3:0]  alu_cmp_out = '0;
    logic [16:0] alu_shift_out = '0;
    logic        alu_arith_flag = 1'b0, alu_logic_flag = 1'b0;
    logic        alu_cmp_flag = 1'b0, alu_shift_flag = 1'b0;
`ifdef ALU_ARB_OPCNT_EN
    logic [15:0] op_cnt0, op_cnt1;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    logic kill     = 1'b0;
    int   last_served = 1;
    int   exp_cnt[2] = '{0, 0};

    always #5 clk = ~clk;

    alu_req_arbiter #(.IN_WIDTH(16), .RES_WIDTH(32), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .busy(busy),
`ifdef ALU_ARB_OPCNT_EN
        .op_cnt0(op_cnt0), .op_cnt1(op_cnt1),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_arith_out(alu_arith_out), .alu_carry(alu_carry),
        .alu_logic_out(alu_logic_out), .alu_cmp_out(alu_cmp_out),
        .alu_shift_out(alu_shift_out),
        .alu_arith_flag(alu_arith_flag), .alu_logic_flag(alu_logic_flag),
        .alu_cmp_flag(alu_cmp_flag), .alu_shift_flag(alu_shift_flag)
    );

    // ALU stand-in: every group output is computed every cycle, one cycle late.
    always @(posedge clk) begin
        logic signed [31:0] sa, sb;
        logic [16:0]        usum;
        sa = {{16{alu_a[15]}}, alu_a};
        sb = {{16{alu_b[15]}}, alu_b};
        usum = {1'b0, alu_a} + {1'b0, alu_b};
        case (alu_fun[1:0])
            2'd0: alu_arith_out <= sa + sb;
            2'd1: alu_arith_out <= sa - sb;
            2'd2: alu_arith_out <= sa * sb;
            default: alu_arith_out <= (sb != 0) ? sa / sb : 32'sd0;
        endcase
        alu_carry <= usum[16];
        case (alu_fun[1:0])
            2'd0: alu_logic_out <= alu_a & alu_b;
            2'd1: alu_logic_out <= alu_a | alu_b;
            2'd2: alu_logic_out <= ~(alu_a & alu_b);
            default: alu_logic_out <= ~(alu_a | alu_b);
        endcase
        case (alu_fun[1:0])
            2'd0: alu_cmp_out <= 4'd0;
            2'd1: alu_cmp_out <= (sa == sb) ? 4'd1 : 4'd0;
            2'd2: alu_cmp_out <= (sa > sb) ? 4'd2 : 4'd0;
            default: alu_cmp_out <= (sa < sb) ? 4'd3 : 4'd0;
        endcase
        case (alu_fun[1:0])
            2'd0: alu_shift_out <= {1'b0, alu_a >> 1};
            2'd1: alu_shift_out <= {alu_a, 1'b0};
            2'd2: alu_shift_out <= {1'b0, alu_b >> 1};
            default: alu_shift_out <= {alu_b, 1'b0};
        endcase
        alu_arith_flag <= (alu_fun[3:2] == 2'd0) && !kill;
        alu_logic_flag <= (alu_fun[3:2] == 2'd1) && !kill;
        alu_cmp_flag   <= (alu_fun[3:2] == 2'd2) && !kill;
        alu_shift_flag <= (alu_fun[3:2] == 2'd3) && !kill;
    end

    // Expected response straight from the opcode table.
    task automatic ref_rsp(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                           output logic [31:0] d, output logic c);
        int ua, ub, sa, sb;
        logic [15:0] t;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = (f < 4) && ((ua + ub) > 65535);
        d = '0;
        case (f)
            4'd0:  d = 32'(sa + sb);
            4'd1:  d = 32'(sa - sb);
            4'd2:  d = 32'(sa * sb);
            4'd3:  d = (sb != 0) ? 32'(sa / sb) : 32'd0;
            4'd4:  begin t = a & b;    d = {16'd0, t}; end
            4'd5:  begin t = a | b;    d = {16'd0, t}; end
            4'd6:  begin t = ~(a & b); d = {16'd0, t}; end
            4'd7:  begin t = ~(a | b); d = {16'd0, t}; end
            4'd8:  d = 32'd0;
            4'd9:  d = (sa == sb) ? 32'd1 : 32'd0;
            4'd10: d = (sa > sb) ? 32'd2 : 32'd0;
            4'd11: d = (sa < sb) ? 32'd3 : 32'd0;
            4'd12: d = 32'(ua / 2);
            4'd13: d = 32'(ua * 2);
            4'd14: d = 32'(ub / 2);
            default: d = 32'(ub * 2);
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        if (r == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fun = f;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fun = f;
        end
    endtask

    // Called just after a rising edge with requests driven; the next edge must accept w.
    task automatic accept(input int w, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        #1;
        chk("grant_ready", (w == 0) ? req0_ready : req1_ready, 1);
        chk("other_ready", (w == 0) ? req1_ready : req0_ready, 0);
        tick();
        if (w == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        last_served = w;
        chk("alu_operands", {alu_fun, alu_a, alu_b}, {f, a, b});
        chk("busy_after_accept", busy, 1);
        chk("rsp_idle_in_wait", {rsp0_valid, rsp1_valid}, 0);
    endtask

    task automatic wait_rsp(input int w, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                            input logic exp_err, input int hold);
        int          cyc;
        logic        v;
        logic [31:0] ed;
        logic        ec;
        cyc = 0;
        v = (w == 0) ? rsp0_valid : rsp1_valid;
        while (!v && cyc < 20) begin
            tick();
            cyc++;
            v = (w == 0) ? rsp0_valid : rsp1_valid;
        end
        chk("rsp_latency", cyc, LAT + 1);
        if (!v) return;
        ref_rsp(f, a, b, ed, ec);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_carry", rsp_carry, ec);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_other_valid", (w == 0) ? rsp1_valid : rsp0_valid, 0);
        if (w == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", (w == 0) ? rsp0_valid : rsp1_valid, 1);
            chk("hold_data", {rsp_data, rsp_carry, rsp_err}, {ed, ec, exp_err});
            chk("hold_busy_ready", {busy, req0_ready, req1_ready}, 3'b100);
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        if (w == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        exp_cnt[w] = (exp_cnt[w] + 1) % 65536;
        chk("after_handshake", {rsp0_valid, rsp1_valid, busy}, 0);
`ifdef ALU_ARB_OPCNT_EN
        chk("op_cnt", {op_cnt0, op_cnt1}, {exp_cnt[0][15:0], exp_cnt[1][15:0]});
`endif
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] pa[2], pb[2];
        logic [3:0]  pf[2];
        bit          pend[2];
        int          w;

        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_fun = 0; req1_a = 0; req1_b = 0; req1_fun = 0;

        // Reset with both requesters pushing: nothing may be granted.
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        #1;
        chk("reset_ready", {req0_ready, req1_ready}, 0);
        chk("reset_status", {busy, rsp0_valid, rsp1_valid, rsp_carry, rsp_err}, 0);
        chk("reset_data", rsp_data, 0);
        chk("reset_alu", {alu_a, alu_b, alu_fun}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Both valid straight out of reset: requester 0 first, then 1, then 0 again.
        set_req(0, 16'd11, 16'd4, 4'd5);
        set_req(1, 16'd4, 16'd6, 4'd2);
        accept(0, 16'd11, 16'd4, 4'd5);
        wait_rsp(0, 16'd11, 16'd4, 4'd5, 1'b0, 0);
        accept(1, 16'd4, 16'd6, 4'd2);
        wait_rsp(1, 16'd4, 16'd6, 4'd2, 1'b0, 0);
        set_req(0, 16'd11, 16'd4, 4'd5);
        set_req(1, 16'd4, 16'd6, 4'd2);
        accept(0, 16'd11, 16'd4, 4'd5);
        wait_rsp(0, 16'd11, 16'd4, 4'd5, 1'b0, 0);
        // Requester 1 still pending; response stalled for 5 cycles.
        accept(1, 16'd4, 16'd6, 4'd2);
        set_req(0, 16'd1, 16'd2, 4'd0);
        wait_rsp(1, 16'd4, 16'd6, 4'd2, 1'b0, 5);
        req0_valid = 1'b0;

        // Lone requester 0, signed add of negatives.
        set_req(0, 16'hFFFC, 16'hFFFA, 4'd0);
        accept(0, 16'hFFFC, 16'hFFFA, 4'd0);
        wait_rsp(0, 16'hFFFC, 16'hFFFA, 4'd0, 1'b0, 0);

        // Compare with its group flag forced low.
        kill = 1'b1;
        set_req(0, 16'd10, 16'd10, 4'd9);
        accept(0, 16'd10, 16'd10, 4'd9);
        wait_rsp(0, 16'd10, 16'd10, 4'd9, 1'b1, 1);
        kill = 1'b0;

        // Shift group: carry must stay low even though the ALU carry line is driven.
        set_req(0, 16'd10, 16'hFFFF, 4'd13);
        accept(0, 16'd10, 16'hFFFF, 4'd13);
        wait_rsp(0, 16'd10, 16'hFFFF, 4'd13, 1'b0, 0);

        // Reset in the middle of WAIT abandons the op.
        set_req(1, 16'd3, 16'd5, 4'd0);
        accept(1, 16'd3, 16'd5, 4'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("midreset_status", {busy, rsp0_valid, rsp1_valid, rsp_carry, rsp_err}, 0);
        chk("midreset_data_alu", {rsp_data, alu_a, alu_b, alu_fun}, 0);
        rst = 1'b0;
        last_served = 1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_rsp_after_reset", {rsp0_valid, rsp1_valid, busy}, 0);
        end
`ifdef ALU_ARB_OPCNT_EN
        chk("op_cnt_reset", {op_cnt0, op_cnt1}, 0);
`endif

        // Randomised traffic against the reference model.
        pend[0] = 0;
        pend[1] = 0;
        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
                    pend[r] = 1;
                    pa[r] = rand_operand();
                    pb[r] = rand_operand();
                    pf[r] = 4'($urandom_range(0, 15));
                    set_req(r, pa[r], pb[r], pf[r]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                w = $urandom_range(0, 1);
                pend[w] = 1;
                pa[w] = rand_operand();
                pb[w] = rand_operand();
                pf[w] = 4'($urandom_range(0, 15));
                set_req(w, pa[w], pb[w], pf[w]);
            end
            w = (pend[0] && pend[1]) ? (1 - last_served) : (pend[0] ? 0 : 1);
            kill = ($urandom_range(0, 3) == 0);
            accept(w, pa[w], pb[w], pf[w]);
            pend[w] = 0;
            wait_rsp(w, pa[w], pb[w], pf[w], kill, $urandom_range(0, 2));
            kill = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
